// File: rtl/dom_tree_builder_pkg.sv
// Shared definitions for the DOM tree builder: tag codes, field widths,
// error codes and the small types used by the builder and its tag stack.

`ifndef DOM_TREE_DEFINES
`define DOM_TREE_DEFINES
`define ELE_TAG_BITES        4
`define ATTRIBUTE_TYPE_BITES 4
`define ATTRIBUTE_VAL_BITES  8
`define TAG_DIV              4'd1
`define TAG_P                4'd2
`define TAG_BODY             4'd3
`define TAG_A                4'd4
`define TAG_IMG              4'd5
`define ERR_NONE             3'd0
`define ERR_MISMATCH         3'd1
`define ERR_UNDERFLOW        3'd2
`define ERR_OVERFLOW         3'd3
`define ERR_ID_EXHAUSTED     3'd4
`endif

package dom_tree_builder_pkg;

    localparam int TAG_W   = `ELE_TAG_BITES;
    localparam int ATYPE_W = `ATTRIBUTE_TYPE_BITES;
    localparam int AVAL_W  = `ATTRIBUTE_VAL_BITES;

    typedef logic [TAG_W-1:0]   tag_t;
    typedef logic [ATYPE_W-1:0] attr_type_t;
    typedef logic [AVAL_W-1:0]  attr_val_t;

    localparam tag_t TAG_DIV  = `TAG_DIV;
    localparam tag_t TAG_P    = `TAG_P;
    localparam tag_t TAG_BODY = `TAG_BODY;
    localparam tag_t TAG_A    = `TAG_A;
    localparam tag_t TAG_IMG  = `TAG_IMG;

    typedef enum logic [2:0] {
        ERR_NONE         = `ERR_NONE,
        ERR_MISMATCH     = `ERR_MISMATCH,
        ERR_UNDERFLOW    = `ERR_UNDERFLOW,
        ERR_OVERFLOW     = `ERR_OVERFLOW,
        ERR_ID_EXHAUSTED = `ERR_ID_EXHAUSTED
    } err_code_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_OPEN,
        S_ATTR,
        S_CLOSE,
        S_ERR
    } state_t;

    // One buffered attribute, held until its element opens.
    typedef struct packed {
        attr_type_t atype;
        attr_val_t  aval;
    } attr_t;

endpackage

// File: rtl/dom_tree_builder_tag_stack.sv
// LIFO of {id, tag} for the currently open elements. Push and pop are
// ignored when full / empty; top_* read as zero when the stack is empty.

module tag_stack #(
    parameter  int DEPTH   = 8,
    parameter  int ID_BITS = 8,
    parameter  int TAG_W   = 4,
    localparam int PTR_W   = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic               pop,
    input  logic [ID_BITS-1:0] push_id,
    input  logic [TAG_W-1:0]   push_tag,
    output logic [ID_BITS-1:0] top_id,
    output logic [TAG_W-1:0]   top_tag,
    output logic [PTR_W-1:0]   count,
    output logic               full,
    output logic               empty
);

    localparam int               IDX_W   = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(DEPTH);

    logic [ID_BITS-1:0] id_mem  [DEPTH];
    logic [TAG_W-1:0]   tag_mem [DEPTH];
    logic [PTR_W-1:0]   sp_q, sp_d;
    logic [IDX_W-1:0]   wr_idx, top_idx;

    assign full    = (sp_q == PTR_MAX);
    assign empty   = (sp_q == '0);
    assign count   = sp_q;
    assign wr_idx  = IDX_W'(sp_q);
    assign top_idx = IDX_W'(sp_q - PTR_ONE);
    assign top_id  = empty ? '0 : id_mem[top_idx];
    assign top_tag = empty ? '0 : tag_mem[top_idx];

    // Next stack pointer: push has priority, both guarded against full/empty.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        sp_d = sp_q;
        if (push && !full) begin
            sp_d = sp_q + PTR_ONE;
        end else if (pop && !empty) begin
            sp_d = sp_q - PTR_ONE;
        end
    end

    // Stack pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
        if (!rst_n) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
    end

    // Entry storage written on push.
    always_ff @(posedge clk) begin
        // NOTE: storage arrays are not reset; the pointer alone defines which entries are valid.
        if (push && !full) begin
            id_mem[wr_idx]  <= push_id;
            tag_mem[wr_idx] <= push_tag;
        end
    end

endmodule

// File: rtl/dom_tree_builder.sv
// Turns the element/attribute event stream from the parser into open-node,
// attribute and close-node records, tracking nesting with a tag stack.

module dom_tree_builder
    import dom_tree_builder_pkg::*;
#(
    parameter  int STACK_DEPTH = 8,
    parameter  int MAX_ATTRS   = 4,
    parameter  int ID_BITS     = 8,
    localparam int DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
    input  logic               clock,
    input  logic               state_enable,
    input  logic               has_finished,
    input  logic [TAG_W-1:0]   element_tag,
    input  logic               is_closing_tag,
    input  logic               has_attribute,
    input  logic [ATYPE_W-1:0] attribute_type,
    input  logic [AVAL_W-1:0]  attribute_value,
    output logic               ready,
    output logic               node_valid,
    output logic               close_valid,
    output logic [ID_BITS-1:0] node_id,
    output logic [ID_BITS-1:0] parent_id,
    output logic [TAG_W-1:0]   node_tag,
    output logic [DEPTH_W-1:0] node_depth,
    output logic               attr_valid,
    output logic [ID_BITS-1:0] attr_node_id,
    output logic [ATYPE_W-1:0] attr_type_out,
    output logic [AVAL_W-1:0]  attr_value_out,
    output logic               doc_done,
    output logic               error,
    output logic [2:0]         error_code,
    output logic               attr_dropped
);

    localparam int                 CNT_W     = $clog2(MAX_ATTRS + 1);
    localparam int                 AIDX_W    = $clog2(MAX_ATTRS);
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]   CNT_MAX   = CNT_W'(MAX_ATTRS);
    localparam logic [DEPTH_W-1:0] DEPTH_ONE = DEPTH_W'(1);
    localparam logic [ID_BITS:0]   ID_ONE    = (ID_BITS + 1)'(1);

    state_t             state_q, state_d;
    logic               fin_q, hattr_q;
    logic               fin_evt, attr_evt;

    attr_t              attr_buf [MAX_ATTRS];
    logic               buf_we;
    logic [CNT_W-1:0]   wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0]   rd_idx_q, rd_idx_d;

    // One extra bit so that running past the last id is directly visible.
    logic [ID_BITS:0]   next_id_q, next_id_d;
    tag_t               cur_tag_q, cur_tag_d;
    logic [ID_BITS-1:0] open_id_q, open_id_d;

    logic               ready_q, ready_d;
    logic               node_valid_q, node_valid_d;
    logic               close_valid_q, close_valid_d;
    logic [ID_BITS-1:0] node_id_q, node_id_d;
    logic [ID_BITS-1:0] parent_id_q, parent_id_d;
    tag_t               node_tag_q, node_tag_d;
    logic [DEPTH_W-1:0] node_depth_q, node_depth_d;
    logic               attr_valid_q, attr_valid_d;
    logic [ID_BITS-1:0] attr_node_id_q, attr_node_id_d;
    attr_type_t         attr_type_q, attr_type_d;
    attr_val_t          attr_value_q, attr_value_d;
    logic               doc_done_q, doc_done_d;
    logic               error_q, error_d;
    err_code_t          error_code_q, error_code_d;
    logic               attr_dropped_q, attr_dropped_d;

    logic               st_push, st_pop, st_full, st_empty;
    logic [ID_BITS-1:0] st_top_id;
    tag_t               st_top_tag;
    logic [DEPTH_W-1:0] st_count;

    tag_stack #(
        .DEPTH   (STACK_DEPTH),
        .ID_BITS (ID_BITS),
        .TAG_W   (TAG_W)
    ) u_tag_stack (
        .clk      (clock),
        .rst_n    (state_enable),
        .push     (st_push),
        .pop      (st_pop),
        .push_id  (next_id_q[ID_BITS-1:0]),
        .push_tag (cur_tag_q),
        .top_id   (st_top_id),
        .top_tag  (st_top_tag),
        .count    (st_count),
        .full     (st_full),
        .empty    (st_empty)
    );

    assign fin_evt  = has_finished  && !fin_q;
    assign attr_evt = has_attribute && !hattr_q;

    // Next-state and record generation for the IDLE/OPEN/ATTR/CLOSE/ERR flow.
    always_comb begin
        state_d        = state_q;
        wr_cnt_d       = wr_cnt_q;
        rd_idx_d       = rd_idx_q;
        next_id_d      = next_id_q;
        cur_tag_d      = cur_tag_q;
        open_id_d      = open_id_q;
        buf_we         = 1'b0;
        st_push        = 1'b0;
        st_pop         = 1'b0;
        node_valid_d   = 1'b0;
        close_valid_d  = 1'b0;
        attr_valid_d   = 1'b0;
        node_id_d      = node_id_q;
        parent_id_d    = parent_id_q;
        node_tag_d     = node_tag_q;
        node_depth_d   = node_depth_q;
        attr_node_id_d = attr_node_id_q;
        attr_type_d    = attr_type_q;
        attr_value_d   = attr_value_q;
        doc_done_d     = doc_done_q;
        error_d        = error_q;
        error_code_d   = error_code_q;
        attr_dropped_d = attr_dropped_q;

        unique case (state_q)
            S_IDLE: begin
                // Attribute is taken before the finish event so a coincident one joins this element.
                if (attr_evt) begin
                    if (wr_cnt_q < CNT_MAX) begin
                        buf_we   = 1'b1;
                        wr_cnt_d = wr_cnt_q + CNT_ONE;
                    end else begin
                        attr_dropped_d = 1'b1;
                    end
                end
                if (fin_evt) begin
                    cur_tag_d = element_tag;
                    state_d   = is_closing_tag ? S_CLOSE : S_OPEN;
                end
            end

            S_OPEN: begin
                if (next_id_q[ID_BITS]) begin
                    error_d      = 1'b1;
                    error_code_d = ERR_ID_EXHAUSTED;
                    state_d      = S_ERR;
                end else if (st_full) begin
                    error_d      = 1'b1;
                    error_code_d = ERR_OVERFLOW;
                    state_d      = S_ERR;
                end else begin
                    node_valid_d = 1'b1;
                    node_id_d    = next_id_q[ID_BITS-1:0];
                    parent_id_d  = st_top_id;
                    node_tag_d   = cur_tag_q;
                    node_depth_d = st_count + DEPTH_ONE;
                    // Void elements get a record but never become a parent.
                    st_push      = (cur_tag_q != TAG_IMG);
                    open_id_d    = next_id_q[ID_BITS-1:0];
                    next_id_d    = next_id_q + ID_ONE;
                    rd_idx_d     = '0;
                    state_d      = (wr_cnt_q != '0) ? S_ATTR : S_IDLE;
                end
            end

            S_ATTR: begin
                attr_valid_d   = 1'b1;
                attr_node_id_d = open_id_q;
                attr_type_d    = attr_buf[rd_idx_q[AIDX_W-1:0]].atype;
                attr_value_d   = attr_buf[rd_idx_q[AIDX_W-1:0]].aval;
                rd_idx_d       = rd_idx_q + CNT_ONE;
                if (rd_idx_q + CNT_ONE == wr_cnt_q) begin
                    wr_cnt_d = '0;
                    state_d  = S_IDLE;
                end
            end

            S_CLOSE: begin
                // Attributes on a closing tag carry no meaning and are thrown away.
                wr_cnt_d = '0;
                if (st_empty) begin
                    error_d      = 1'b1;
                    error_code_d = ERR_UNDERFLOW;
                    state_d      = S_ERR;
                end else if (st_top_tag != cur_tag_q) begin
                    error_d      = 1'b1;
                    error_code_d = ERR_MISMATCH;
                    state_d      = S_ERR;
                end else begin
                    st_pop        = 1'b1;
                    close_valid_d = 1'b1;
                    node_id_d     = st_top_id;
                    node_tag_d    = st_top_tag;
                    node_depth_d  = st_count;
                    if (st_top_tag == TAG_BODY && st_count == DEPTH_ONE) begin
                        doc_done_d = 1'b1;
                    end
                    state_d = S_IDLE;
                end
            end

            S_ERR: begin
                state_d = S_ERR;
            end

            default: begin
                state_d = S_ERR;
            end
        endcase

        ready_d = (state_d == S_IDLE);
    end

    // Control state, edge detectors and registered outputs.
    always_ff @(posedge clock or negedge state_enable) begin
        if (!state_enable) begin
            state_q        <= S_IDLE;
            fin_q          <= 1'b0;
            hattr_q        <= 1'b0;
            wr_cnt_q       <= '0;
            rd_idx_q       <= '0;
            next_id_q      <= ID_ONE;
            cur_tag_q      <= '0;
            open_id_q      <= '0;
            ready_q        <= 1'b1;
            node_valid_q   <= 1'b0;
            close_valid_q  <= 1'b0;
            node_id_q      <= '0;
            parent_id_q    <= '0;
            node_tag_q     <= '0;
            node_depth_q   <= '0;
            attr_valid_q   <= 1'b0;
            attr_node_id_q <= '0;
            attr_type_q    <= '0;
            attr_value_q   <= '0;
            doc_done_q     <= 1'b0;
            error_q        <= 1'b0;
            error_code_q   <= ERR_NONE;
            attr_dropped_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            fin_q          <= has_finished;
            hattr_q        <= has_attribute;
            wr_cnt_q       <= wr_cnt_d;
            rd_idx_q       <= rd_idx_d;
            next_id_q      <= next_id_d;
            cur_tag_q      <= cur_tag_d;
            open_id_q      <= open_id_d;
            ready_q        <= ready_d;
            node_valid_q   <= node_valid_d;
            close_valid_q  <= close_valid_d;
            node_id_q      <= node_id_d;
            parent_id_q    <= parent_id_d;
            node_tag_q     <= node_tag_d;
            node_depth_q   <= node_depth_d;
            attr_valid_q   <= attr_valid_d;
            attr_node_id_q <= attr_node_id_d;
            attr_type_q    <= attr_type_d;
            attr_value_q   <= attr_value_d;
            doc_done_q     <= doc_done_d;
            error_q        <= error_d;
            error_code_q   <= error_code_d;
            attr_dropped_q <= attr_dropped_d;
        end
    end

    // Pending attribute storage, written in arrival order while idle.
    always_ff @(posedge clock) begin
        if (buf_we) begin
            attr_buf[wr_cnt_q[AIDX_W-1:0]] <= {attribute_type, attribute_value};
        end
    end

    assign ready          = ready_q;
    assign node_valid     = node_valid_q;
    assign close_valid    = close_valid_q;
    assign node_id        = node_id_q;
    assign parent_id      = parent_id_q;
    assign node_tag       = node_tag_q;
    assign node_depth     = node_depth_q;
    assign attr_valid     = attr_valid_q;
    assign attr_node_id   = attr_node_id_q;
    assign attr_type_out  = attr_type_q;
    assign attr_value_out = attr_value_q;
    assign doc_done       = doc_done_q;
    assign error          = error_q;
    assign error_code     = error_code_q;
    assign attr_dropped   = attr_dropped_q;

endmodule

// File: tb/tb_dom_tree_builder.sv
// Directed bench for dom_tree_builder: a queue-based document model predicts
// every record and flag; one compare process checks each output pulse.

module tb_dom_tree_builder;
    import dom_tree_builder_pkg::*;

    localparam int STACK_DEPTH = 8;
    localparam int MAX_ATTRS   = 4;
    localparam int ID_BITS     = 8;
    localparam int DEPTH_W     = $clog2(STACK_DEPTH + 1);

    logic               clock = 1'b0;
    logic               state_enable = 1'b0;
    logic               has_finished = 1'b0;
    logic [TAG_W-1:0]   element_tag = '0;
    logic               is_closing_tag = 1'b0;
    logic               has_attribute = 1'b0;
    logic [ATYPE_W-1:0] attribute_type = '0;
    logic [AVAL_W-1:0]  attribute_value = '0;
    logic               ready, node_valid, close_valid, attr_valid;
    logic [ID_BITS-1:0] node_id, parent_id, attr_node_id;
    logic [TAG_W-1:0]   node_tag;
    logic [DEPTH_W-1:0] node_depth;
    logic [ATYPE_W-1:0] attr_type_out;
    logic [AVAL_W-1:0]  attr_value_out;
    logic               doc_done, error, attr_dropped;
    logic [2:0]         error_code;

    always #5 clock = ~clock;

    dom_tree_builder #(
        .STACK_DEPTH (STACK_DEPTH),
        .MAX_ATTRS   (MAX_ATTRS),
        .ID_BITS     (ID_BITS)
    ) dut (
        .clock           (clock),
        .state_enable    (state_enable),
        .has_finished    (has_finished),
        .element_tag     (element_tag),
        .is_closing_tag  (is_closing_tag),
        .has_attribute   (has_attribute),
        .attribute_type  (attribute_type),
        .attribute_value (attribute_value),
        .ready           (ready),
        .node_valid      (node_valid),
        .close_valid     (close_valid),
        .node_id         (node_id),
        .parent_id       (parent_id),
        .node_tag        (node_tag),
        .node_depth      (node_depth),
        .attr_valid      (attr_valid),
        .attr_node_id    (attr_node_id),
        .attr_type_out   (attr_type_out),
        .attr_value_out  (attr_value_out),
        .doc_done        (doc_done),
        .error           (error),
        .error_code      (error_code),
        .attr_dropped    (attr_dropped)
    );

    // ---------------- document model ----------------
    typedef struct {
        int kind;   // 0 open, 1 attribute, 2 close
        int id;
        int parent;
        int tag;
        int depth;
        int atype;
        int aval;
    } rec_t;

    typedef struct {
        int id;
        int tag;
    } open_t;

    rec_t  exp_q[$];
    open_t m_stack[$];
    int    m_attr_t[$];
    int    m_attr_v[$];
    int    m_next_id;
    bit    m_err;
    int    m_code;
    bit    m_doc;
    bit    m_drop;

    int n_vec  = 0;
    int n_miss = 0;

    // observations gathered by the compare process, used for literal pins
    int node_cnt, attr_cnt, close_cnt;
    int last_node_id, last_parent, last_depth, last_attr_node;
    int close_log[$];
    int lat_node, lat_attr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic m_reset();
        exp_q.delete();
        m_stack.delete();
        m_attr_t.delete();
        m_attr_v.delete();
        m_next_id = 1;
        m_err     = 1'b0;
        m_code    = 0;
        m_doc     = 1'b0;
        m_drop    = 1'b0;
    endtask

    task automatic clear_obs();
        node_cnt = 0; attr_cnt = 0; close_cnt = 0;
        last_node_id = -1; last_parent = -1; last_depth = -1; last_attr_node = -1;
        close_log.delete();
    endtask

    task automatic m_attr(input int t, input int v);
        if (m_err) return;
        if (m_attr_t.size() < MAX_ATTRS) begin
            m_attr_t.push_back(t);
            m_attr_v.push_back(v);
        end else begin
            m_drop = 1'b1;
        end
    endtask

    task automatic m_elem(input int tag, input bit closing);
        rec_t r;
        if (m_err) return;
        if (!closing) begin
            if (m_next_id == (1 << ID_BITS)) begin
                m_err = 1'b1; m_code = 4;
            end else if (m_stack.size() == STACK_DEPTH) begin
                m_err = 1'b1; m_code = 3;
            end else begin
                r = '{kind: 0, id: m_next_id,
                      parent: (m_stack.size() > 0) ? m_stack[$].id : 0,
                      tag: tag, depth: m_stack.size() + 1, atype: 0, aval: 0};
                exp_q.push_back(r);
                for (int i = 0; i < m_attr_t.size(); i++) begin
                    r = '{kind: 1, id: m_next_id, parent: 0, tag: 0, depth: 0,
                          atype: m_attr_t[i], aval: m_attr_v[i]};
                    exp_q.push_back(r);
                end
                if (tag != int'(TAG_IMG)) m_stack.push_back('{id: m_next_id, tag: tag});
                m_next_id++;
            end
        end else begin
            if (m_stack.size() == 0) begin
                m_err = 1'b1; m_code = 2;
            end else if (m_stack[$].tag != tag) begin
                m_err = 1'b1; m_code = 1;
            end else begin
                r = '{kind: 2, id: m_stack[$].id, parent: 0, tag: tag,
                      depth: m_stack.size(), atype: 0, aval: 0};
                exp_q.push_back(r);
                void'(m_stack.pop_back());
                if (tag == int'(TAG_BODY) && m_stack.size() == 0) m_doc = 1'b1;
            end
        end
        m_attr_t.delete();
        m_attr_v.delete();
    endtask

    // ---------------- compare process ----------------
    initial begin : compare
        rec_t e;
        int   kind;
        forever begin
            @(negedge clock);
            if (state_enable && (node_valid || attr_valid || close_valid)) begin
                check("single_valid", int'(node_valid) + int'(attr_valid) + int'(close_valid), 1);
                kind = node_valid ? 0 : (attr_valid ? 1 : 2);
                check("record_pending", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("record_kind", kind, e.kind);
                    if (kind == 0) begin
                        check("open_id", node_id, e.id);
                        check("open_parent", parent_id, e.parent);
                        check("open_tag", node_tag, e.tag);
                        check("open_depth", node_depth, e.depth);
                        node_cnt++;
                        last_node_id = node_id; last_parent = parent_id; last_depth = node_depth;
                    end else if (kind == 1) begin
                        check("attr_node_id", attr_node_id, e.id);
                        check("attr_type", attr_type_out, e.atype);
                        check("attr_value", attr_value_out, e.aval);
                        attr_cnt++;
                        last_attr_node = attr_node_id;
                    end else begin
                        check("close_id", node_id, e.id);
                        check("close_tag", node_tag, e.tag);
                        check("close_depth", node_depth, e.depth);
                        close_cnt++;
                        close_log.push_back(int'(node_id));
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_attr(input int t, input int v);
        m_attr(t, v);
        @(negedge clock);
        attribute_type  = ATYPE_W'(t);
        attribute_value = AVAL_W'(v);
        has_attribute   = 1'b1;
        @(negedge clock);
        has_attribute = 1'b0;
        @(negedge clock);
    endtask

    task automatic element(input int tag, input bit closing,
                           input bit coinc = 1'b0, input int ct = 0, input int cv = 0);
        bit done;
        if (coinc) m_attr(ct, cv);
        m_elem(tag, closing);
        @(negedge clock);
        element_tag    = TAG_W'(tag);
        is_closing_tag = closing;
        has_finished   = 1'b1;
        if (coinc) begin
            attribute_type  = ATYPE_W'(ct);
            attribute_value = AVAL_W'(cv);
            has_attribute   = 1'b1;
        end
        lat_node = -1; lat_attr = -1; done = 1'b0;
        for (int k = 0; k < 16 && !done; k++) begin
            @(negedge clock);
            if (k == 0) begin
                has_finished  = 1'b0;
                has_attribute = 1'b0;
            end
            if (node_valid && lat_node < 0) lat_node = k;
            if (attr_valid && lat_attr < 0) lat_attr = k;
            if (ready && k > 0) done = 1'b1;
        end
        #1;
        if (!m_err) check("ready_returned", done, 1);
        check("records_drained", exp_q.size(), 0);
        check("ready_level", ready, !m_err);
        check("error_flag", error, m_err);
        check("error_code", error_code, m_code);
        check("doc_done", doc_done, m_doc);
        check("attr_dropped", attr_dropped, m_drop);
    endtask

    task automatic do_reset();
        @(negedge clock);
        state_enable  = 1'b0;
        has_finished  = 1'b0;
        has_attribute = 1'b0;
        m_reset();
        clear_obs();
        @(negedge clock);
        @(negedge clock);
        state_enable = 1'b1;
        #1;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : main
        bit seen;

        // Reset state
        do_reset();
        check("rst_ready", ready, 1);
        check("rst_node_valid", node_valid, 0);
        check("rst_attr_valid", attr_valid, 0);
        check("rst_close_valid", close_valid, 0);
        check("rst_error", error, 0);
        check("rst_error_code", error_code, 0);
        check("rst_doc_done", doc_done, 0);
        check("rst_attr_dropped", attr_dropped, 0);
        check("rst_node_id", node_id, 0);
        check("rst_parent_id", parent_id, 0);

        // body > div(2 attrs), then close both
        element(int'(TAG_BODY), 1'b0);
        check("t1_body_id", last_node_id, 1);
        check("t1_body_parent", last_parent, 0);
        check("t1_body_depth", last_depth, 1);
        send_attr(2, 8'h11);
        send_attr(7, 8'hC3);
        element(int'(TAG_DIV), 1'b0);
        check("t1_open_latency", lat_node, 1);
        check("t1_attr_latency", lat_attr, 2);
        check("t1_div_id", last_node_id, 2);
        check("t1_div_parent", last_parent, 1);
        check("t1_div_depth", last_depth, 2);
        check("t1_attr_count", attr_cnt, 2);
        check("t1_attr_owner", last_attr_node, 2);
        element(int'(TAG_DIV), 1'b1);
        element(int'(TAG_BODY), 1'b1);
        check("t1_close_count", close_log.size(), 2);
        if (close_log.size() == 2) begin
            check("t1_close_first", close_log[0], 2);
            check("t1_close_second", close_log[1], 1);
        end
        check("t1_doc_done", doc_done, 1);

        // open p, close a -> mismatch
        do_reset();
        element(int'(TAG_P), 1'b0);
        element(int'(TAG_A), 1'b1);
        repeat (4) @(negedge clock);
        check("t2_error", error, 1);
        check("t2_code", error_code, 1);
        check("t2_ready_held", ready, 0);
        check("t2_no_close", close_cnt, 0);

        // close with empty stack -> underflow
        do_reset();
        element(int'(TAG_DIV), 1'b1);
        check("t3_code", error_code, 2);

        // nine nested opens into an eight-deep stack -> overflow
        do_reset();
        for (int i = 0; i < 9; i++) element(int'(TAG_DIV), 1'b0);
        check("t4_node_count", node_cnt, 8);
        check("t4_code", error_code, 3);
        check("t4_ready_held", ready, 0);

        // six attributes on one div, then a void img inside it
        do_reset();
        for (int i = 0; i < 6; i++) send_attr(i + 1, 8'h40 + i);
        element(int'(TAG_DIV), 1'b0);
        check("t5_attr_count", attr_cnt, 4);
        check("t5_dropped", attr_dropped, 1);
        element(int'(TAG_IMG), 1'b0);
        check("t5_img_id", last_node_id, 2);
        check("t5_img_parent", last_parent, 1);
        element(int'(TAG_DIV), 1'b1);
        check("t5_close_count", close_cnt, 1);
        check("t5_error", error, 0);

        // reset while the attribute drain is in progress
        do_reset();
        for (int i = 0; i < 4; i++) send_attr(9, 8'h90 + i);
        m_elem(int'(TAG_DIV), 1'b0);
        @(negedge clock);
        element_tag    = TAG_DIV;
        is_closing_tag = 1'b0;
        has_finished   = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clock);
            has_finished = 1'b0;
            if (attr_valid) seen = 1'b1;
        end
        check("t6_drain_started", seen, 1);
        #2;
        state_enable = 1'b0;
        #1;
        check("t6_attr_valid_drop", attr_valid, 0);
        check("t6_ready", ready, 1);
        m_reset();
        clear_obs();
        @(negedge clock);
        @(negedge clock);
        check("t6_no_pulse_in_reset", attr_valid, 0);
        state_enable = 1'b1;
        element(int'(TAG_P), 1'b0);
        check("t6_restart_id", last_node_id, 1);
        check("t6_no_stale_attrs", attr_cnt, 0);

        // attribute arriving in the same cycle as the finish event
        do_reset();
        element(int'(TAG_DIV), 1'b0, 1'b1, 3, 8'h5A);
        check("t7_attr_count", attr_cnt, 1);
        check("t7_attr_owner", last_attr_node, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/dom_tree_builder.md
DOM_TREE_BUILDER -- requirements
Module: dom_tree_builder

Interface
REQ-001 SHALL have parameter STACK_DEPTH, default 8, giving the maximum number of simultaneously open elements.
REQ-002 SHALL have parameter MAX_ATTRS, default 4, giving the number of attributes buffered per element.
REQ-003 SHALL have parameter ID_BITS, default 8, giving the node-id width.
REQ-004 SHALL have ports, one clock and one reset, with reset asynchronous and active-low:
- clock  in  1  global clock.
- state_enable  in  1  asynchronous active-low reset.
- has_finished  in  1  element-parser done flag; a level signal, consumed on its rising edge.
- element_tag  in  `ELE_TAG_BITES  tag code of the finished element.
- is_closing_tag  in  1  1 means closing tag.
- has_attribute  in  1  attribute-present flag, consumed on its rising edge.
- attribute_type  in  `ATTRIBUTE_TYPE_BITES  attribute type.
- attribute_value  in  `ATTRIBUTE_VAL_BITES  attribute value.
- ready  out  1  1 when a new element may be parsed.
- node_valid  out  1  one-cycle pulse carrying an open-node record.
- close_valid  out  1  one-cycle pulse carrying a closed-node record.
- node_id  out  ID_BITS  id of the opened or closed node.
- parent_id  out  ID_BITS  parent id; 0 means root.
- node_tag  out  `ELE_TAG_BITES  tag code.
- node_depth  out  clog2(STACK_DEPTH+1)  depth; the root child is 1.
- attr_valid  out  1  one-cycle pulse per attribute record.
- attr_node_id  out  ID_BITS  owning node id.
- attr_type_out  out  `ATTRIBUTE_TYPE_BITES  attribute type.
- attr_value_out  out  `ATTRIBUTE_VAL_BITES  attribute value.
- doc_done  out  1  sticky; set when the stack returns to empty after a TAG_BODY close.
- error  out  1  sticky error flag.
- error_code  out  3  1 mismatch, 2 underflow, 3 overflow, 4 id exhausted; 0 none.
- attr_dropped  out  1  sticky; set when more than MAX_ATTRS attributes are received.

Function
REQ-005 SHALL register has_finished and has_attribute each cycle and treat a 0-to-1 transition as an event.
REQ-006 SHALL, in IDLE, store each attribute event into the pending buffer at write index 0..MAX_ATTRS-1.
REQ-007 SHALL, on an attribute event with the buffer full, discard the attribute and set attr_dropped.
REQ-008 SHALL, on a has_finished event in IDLE, deassert ready on the next cycle and move to OPEN or CLOSE according to is_closing_tag.
REQ-009 SHALL, in OPEN, assert node_valid for exactly one cycle: node_id is the next id, parent_id is the stack top (0 if empty), and node_depth is the current depth + 1.
REQ-010 SHALL assign ids from 1 upward, incrementing on every open.
REQ-011 SHALL, on an open with next id equal to 2^ID_BITS, set error with code 4 instead of emitting.
REQ-012 SHALL push the id and tag on open, except for TAG_IMG, which is a void element and is never pushed.
REQ-013 SHALL, on an open with the stack full, set error with code 3, emit nothing, and push nothing.
REQ-014 SHALL, after OPEN, go to ATTR, emitting one attr_valid per buffered attribute per cycle in arrival order with attr_node_id equal to the new id, then clear the buffer.
REQ-015 SHALL, with an empty buffer, go from OPEN directly to IDLE.
REQ-016 SHALL, in CLOSE with a stack top tag equal to element_tag, pop the stack and assert close_valid for one cycle with the popped id, tag, and pre-pop depth.
REQ-017 SHALL, in CLOSE, discard any buffered attributes without emitting them.
REQ-018 SHALL, in CLOSE with the stack empty, set error with code 2; with a tag mismatch, set error with code 1; in both cases the stack is unchanged.
REQ-019 SHALL set doc_done when a close of TAG_BODY leaves the stack empty.
REQ-020 SHALL, on any error, enter ERR: ready stays 0, all valids stay 0, and the block holds until reset.
REQ-021 SHALL drive ready=1 only in IDLE.
REQ-022 SHALL give open latency of the has_finished event edge + 1 cycle to node_valid, and the first attr_valid on the following cycle.
REQ-023 SHALL, when a has_finished event and an attribute event coincide, accept the attribute first so that it belongs to that element.

Reset
REQ-024 SHALL, on state_enable=0, asynchronously clear the state to IDLE, the stack pointer, buffer, edge registers, all valids, error, error_code, attr_dropped, and doc_done.
REQ-025 SHALL, on state_enable=0, set the next id to 1, ready to 1, and all data outputs to 0.
REQ-026 SHALL, on a reset during ATTR drain, lose the remaining attributes with no further pulses.

Structure
REQ-027 SHALL take the tag codes (TAG_DIV, TAG_P, TAG_BODY, TAG_A, TAG_IMG), width macros, and error codes from the shared defines file; error codes are added there.
REQ-028 SHALL have one natural sub-module, tag_stack: a LIFO of {id, tag} with push, pop, top, full, and empty.

Verification
REQ-029 SHALL cover: open body, open div with 2 attributes, close div, close body -> node ids 1 and 2; node 2 with parent 1 and depth 2; 2 attr_valid pulses with node id 2; close_valid for 2 then 1; doc_done=1.
REQ-030 SHALL cover: open p, then close a -> error=1, error_code=1, ready held at 0, no close_valid.
REQ-031 SHALL cover: close div at reset state -> error_code=2.
REQ-032 SHALL cover: 9 nested div opens with STACK_DEPTH=8 -> 8 node_valid pulses, then error_code=3.
REQ-033 SHALL cover: open div with 6 attributes -> 4 attr_valid pulses and attr_dropped=1; open img inside div -> parent_id is the div id, and a following close div matches.
REQ-034 SHALL cover: reset asserted mid-ATTR drain -> attr_valid drops immediately, ready=1, and the next open gets node_id 1.
